// File: rtl/data_mem_port_pkg.sv
// Shared types and constants for the load-side data memory port.
// FSM state encoding, access-size encodings and the default bus timeout.
package data_mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/data_mem_align.sv
// Combinational alignment helper: misalignment/illegal-size detection and
// extraction of the addressed lane from a bus word, right-aligned and zero-filled.
module data_mem_align
  import data_mem_port_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    misalign = 1'b0;
    illegal  = 1'b0;
    data     = 32'd0;
    case (size)
      SIZE_BYTE: data = {24'd0, shifted[7:0]};
      SIZE_HALF: begin
        misalign = addr_lo[0];
        data     = {16'd0, shifted[15:0]};
      end
      SIZE_WORD: begin
        misalign = (addr_lo != 2'b00);
        data     = shifted;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Load data memory port: turns a held load request into one bus read and a
// one-cycle completion pulse. Optional bus timeout via DATA_MEM_PORT_TIMEOUT_EN.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] mem_data_addr,
  input  logic        mem_data_addr_valid,
  input  logic [1:0]  mem_data_size,
  output logic [31:0] mem_data_in,
  output logic        mem_data_valid,
  output logic        mem_data_access_fault,
  output logic        mem_data_misalign,
  output logic        bus_req,
  output logic [29:0] bus_addr,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [1:0]  size_reg, size_next;
  logic [31:0] data_reg, data_next;
  logic        fault_reg, fault_next;
  logic        misalign_reg, misalign_next;

  logic [1:0]  align_addr;
  logic [1:0]  align_size;
  logic        align_misalign;
  logic        align_illegal;
  logic [31:0] align_data;
  logic        timeout;

  // In IDLE the checker looks at the live request; afterwards at the captured one.
  assign align_addr = (state_reg == ST_IDLE) ? mem_data_addr[1:0] : addr_reg[1:0];
  assign align_size = (state_reg == ST_IDLE) ? mem_data_size : size_reg;

  data_mem_align u_align (
    .addr_lo  (align_addr),
    .size     (align_size),
    .rdata    (bus_rdata),
    .misalign (align_misalign),
    .illegal  (align_illegal),
    .data     (align_data)
  );

`ifdef DATA_MEM_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = '0;
    if (state_next == state_reg && (state_reg == ST_REQ || state_reg == ST_DRAIN))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= 32'd0;
      size_reg     <= SIZE_BYTE;
      data_reg     <= 32'd0;
      fault_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      data_reg     <= data_next;
      fault_reg    <= fault_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        if (mem_data_addr_valid && !flush)
          state_next = (align_misalign || align_illegal) ? ST_RESP : ST_REQ;
      ST_REQ:
        // A flush racing the bus response or timeout has nothing left to drain.
        if (bus_ack || bus_err || timeout) state_next = flush ? ST_IDLE : ST_RESP;
        else if (flush)                    state_next = ST_DRAIN;
      ST_RESP:
        state_next = ST_IDLE;
      ST_DRAIN:
        if (bus_ack || bus_err || timeout) state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_next     = addr_reg;
    size_next     = size_reg;
    data_next     = data_reg;
    fault_next    = fault_reg;
    misalign_next = misalign_reg;
    case (state_reg)
      ST_IDLE:
        if (mem_data_addr_valid && !flush) begin
          addr_next     = mem_data_addr;
          size_next     = mem_data_size;
          data_next     = 32'd0;
          fault_next    = align_misalign || align_illegal;
          misalign_next = align_misalign;
        end
      ST_REQ:
        if (bus_err || (timeout && !bus_ack)) begin
          data_next     = 32'd0;
          fault_next    = 1'b1;
          misalign_next = 1'b0;
        end else if (bus_ack) begin
          data_next     = align_data;
          fault_next    = 1'b0;
          misalign_next = 1'b0;
        end
      default: ;
    endcase
  end

  always_comb begin
    mem_data_valid        = (state_reg == ST_RESP) && !flush;
    mem_data_in           = mem_data_valid ? data_reg : 32'd0;
    mem_data_access_fault = mem_data_valid && fault_reg;
    mem_data_misalign     = mem_data_valid && misalign_reg;
    bus_req               = (state_reg == ST_REQ) || (state_reg == ST_DRAIN);
    bus_addr              = addr_reg[31:2];
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: vector table plus scoreboard,
// and hand sequences for flush, reset and (when enabled) timeout corners.
module tb_data_mem_port;
  import data_mem_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] mem_data_addr = 32'd0;
  logic        mem_data_addr_valid = 1'b0;
  logic [1:0]  mem_data_size = 2'b00;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_data_access_fault;
  logic        mem_data_misalign;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          delay;
    logic        ack;
    logic        err;
    logic [31:0] exp_data;
    logic        exp_fault;
    logic        exp_mis;
    logic        exp_bus;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        mis;
  } resp_t;

  vec_t  vecs[12];
  resp_t sb_q[$];

  data_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .flush                 (flush),
    .mem_data_addr         (mem_data_addr),
    .mem_data_addr_valid   (mem_data_addr_valid),
    .mem_data_size         (mem_data_size),
    .mem_data_in           (mem_data_in),
    .mem_data_valid        (mem_data_valid),
    .mem_data_access_fault (mem_data_access_fault),
    .mem_data_misalign     (mem_data_misalign),
    .bus_req               (bus_req),
    .bus_addr              (bus_addr),
    .bus_ack               (bus_ack),
    .bus_err               (bus_err),
    .bus_rdata             (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mem_data_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got data=%h fault=%b mis=%b want no pulse",
                 mem_data_in, mem_data_access_fault, mem_data_misalign);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        if (mem_data_in !== e.data || mem_data_access_fault !== e.fault ||
            mem_data_misalign !== e.mis) begin
          bad++;
          $display("FAIL resp: got data=%h fault=%b mis=%b want data=%h fault=%b mis=%b",
                   mem_data_in, mem_data_access_fault, mem_data_misalign,
                   e.data, e.fault, e.mis);
        end
      end
    end else begin
      total++;
      if (mem_data_in !== 32'd0 || mem_data_access_fault !== 1'b0 || mem_data_misalign !== 1'b0) begin
        bad++;
        $display("FAIL idle_zero: got data=%h fault=%b mis=%b want all zero",
                 mem_data_in, mem_data_access_fault, mem_data_misalign);
      end
    end
  end

  task automatic run_vec(input int i);
    vec_t  v;
    resp_t r;
    v = vecs[i];
    @(posedge clk); #1;
    $display("txn %0d addr=%h size=%0d rdata=%h delay=%0d ack=%b err=%b",
             i, v.addr, v.size, v.rdata, v.delay, v.ack, v.err);
    mem_data_addr       = v.addr;
    mem_data_size       = v.size;
    mem_data_addr_valid = 1'b1;
    r.data = v.exp_data; r.fault = v.exp_fault; r.mis = v.exp_mis;
    sb_q.push_back(r);
    @(posedge clk); #1;
    chk("bus_req_rise", {31'd0, bus_req}, {31'd0, v.exp_bus});
    if (v.exp_bus) begin
      chk("bus_addr", {2'b00, bus_addr}, v.addr >> 2);
      for (int d = 0; d < v.delay; d++) begin
        @(posedge clk); #1;
      end
      bus_ack   = v.ack;
      bus_err   = v.err;
      bus_rdata = v.rdata;
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = 32'd0;
      chk("bus_req_drop", {31'd0, bus_req}, 32'd0);
    end
    @(negedge clk);
    chk("valid_latency", {31'd0, mem_data_valid}, 32'd1);
    @(posedge clk); #1;
    mem_data_addr_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1000, SIZE_WORD,    32'hDEADBEEF, 3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'h0000_1003, SIZE_BYTE,    32'h80112233, 0, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_1002, SIZE_HALF,    32'h80112233, 0, 1'b1, 1'b0, 32'h0000_8011, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h0000_1000, SIZE_BYTE,    32'h80112233, 0, 1'b1, 1'b0, 32'h0000_0033, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_1001, SIZE_BYTE,    32'h80112233, 1, 1'b1, 1'b0, 32'h0000_0022, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000_1000, SIZE_HALF,    32'h80112233, 1, 1'b1, 1'b0, 32'h0000_2233, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000_1001, SIZE_HALF,    32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_1000, SIZE_ILLEGAL, 32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_1002, SIZE_WORD,    32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_2000, SIZE_WORD,    32'h12345678, 1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_2004, SIZE_WORD,    32'hCAFEF00D, 0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_1002, SIZE_BYTE,    32'h80112233, 2, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req",  {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", {2'b00, bus_addr}, 32'd0);
    chk("rst_valid",    {31'd0, mem_data_valid}, 32'd0);
    chk("rst_data_in",  mem_data_in, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Flush while the bus cycle is outstanding: drain until ack, no pulse.
    @(posedge clk); #1;
    $display("txn flush_in_req addr=00001004");
    mem_data_addr = 32'h0000_1004; mem_data_size = SIZE_WORD; mem_data_addr_valid = 1'b1;
    @(posedge clk); #1;
    chk("fl_req_busreq", {31'd0, bus_req}, 32'd1);
    flush = 1'b1; mem_data_addr_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_drain_busreq1", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    chk("fl_drain_busreq2", {31'd0, bus_req}, 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    chk("fl_drain_done", {31'd0, bus_req}, 32'd0);
    run_vec(0);

    // Flush in RESP suppresses the pulse.
    @(posedge clk); #1;
    $display("txn flush_in_resp addr=00001001");
    mem_data_addr = 32'h0000_1001; mem_data_size = SIZE_HALF; mem_data_addr_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_resp_valid", {31'd0, mem_data_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; mem_data_addr_valid = 1'b0;

    // Flush in IDLE ignores the request; stray ack in IDLE is ignored.
    @(posedge clk); #1;
    $display("txn flush_in_idle addr=00001000");
    mem_data_addr = 32'h0000_1000; mem_data_size = SIZE_WORD; mem_data_addr_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_idle_busreq", {31'd0, bus_req}, 32'd0);
    mem_data_addr_valid = 1'b0; flush = 1'b0; bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle_ack_busreq", {31'd0, bus_req}, 32'd0);

    // Reset in the middle of REQ clears outputs immediately; late ack ignored.
    @(posedge clk); #1;
    $display("txn reset_mid_req addr=00003000");
    mem_data_addr = 32'h0000_3000; mem_data_size = SIZE_WORD; mem_data_addr_valid = 1'b1;
    @(posedge clk); #1;
    chk("rmid_busreq_pre", {31'd0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rmid_busreq",  {31'd0, bus_req}, 32'd0);
    chk("rmid_bus_addr", {2'b00, bus_addr}, 32'd0);
    chk("rmid_valid",   {31'd0, mem_data_valid}, 32'd0);
    mem_data_addr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    chk("rmid_late_ack", {31'd0, bus_req}, 32'd0);
    run_vec(1);

`ifdef DATA_MEM_PORT_TIMEOUT_EN
    begin
      resp_t r;
      @(posedge clk); #1;
      $display("txn timeout addr=00001008");
      mem_data_addr = 32'h0000_1008; mem_data_size = SIZE_WORD; mem_data_addr_valid = 1'b1;
      r.data = 32'd0; r.fault = 1'b1; r.mis = 1'b0;
      sb_q.push_back(r);
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        chk("to_busreq_hold", {31'd0, bus_req}, 32'd1);
      end
      @(posedge clk); #1;
      chk("to_busreq_drop", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      chk("to_valid", {31'd0, mem_data_valid}, 32'd1);
      @(posedge clk); #1;
      mem_data_addr_valid = 1'b0;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, bus cycles without ack/err before fault (used only with the timeout feature).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  pipeline flush, discards the in-flight load.
REQ-005 SHALL have port mem_data_addr  input  32  byte address from the load execute stage.
REQ-006 SHALL have port mem_data_addr_valid  input  1  load request, held until mem_data_valid.
REQ-007 SHALL have port mem_data_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port mem_data_in  output  32  loaded data, right-aligned, zero-filled above size.
REQ-009 SHALL have port mem_data_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_data_access_fault  output  1  fault qualifier, meaningful only with mem_data_valid.
REQ-011 SHALL have port mem_data_misalign  output  1  misalignment qualifier, meaningful only with mem_data_valid.
REQ-012 SHALL have port bus_req  output  1  bus read request, held until bus_ack or bus_err.
REQ-013 SHALL have port bus_addr  output  30  word address, mem_data_addr[31:2].
REQ-014 SHALL have port bus_ack  input  1  read completed, bus_rdata valid.
REQ-015 SHALL have port bus_err  input  1  bus error, terminates the request.
REQ-016 SHALL have port bus_rdata  input  32  word read data.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP, DRAIN.
REQ-018 IDLE with mem_data_addr_valid and !flush SHALL capture addr/size; aligned: go to REQ; misaligned or size 11: go to RESP with fault=1, misalign=1 for misaligned, misalign=0 for size 11, and no bus cycle.
REQ-019 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 REQ SHALL assert bus_req from registered state; bus_addr SHALL be driven from the captured address, not from the live input.
REQ-021 REQ with bus_ack SHALL register bus_rdata shifted right by 8*addr[1:0] and masked to size, then go to RESP, fault=0.
REQ-022 REQ with bus_err SHALL go to RESP with fault=1 and data 0; bus_err SHALL win if it arrives in the same cycle as bus_ack.
REQ-023 RESP SHALL assert mem_data_valid for exactly one cycle, then go to IDLE.
REQ-024 Minimum latency: addr_valid in cycle 0 and ack in cycle 1 SHALL give mem_data_valid in cycle 2.
REQ-025 Flush in REQ SHALL go to DRAIN, which keeps bus_req high until bus_ack or bus_err, discards the result, and returns to IDLE without a mem_data_valid.
REQ-026 Flush in RESP SHALL suppress mem_data_valid and return to IDLE; flush in IDLE SHALL ignore the request.
REQ-027 While mem_data_valid=0, mem_data_in SHALL be 0 and both qualifiers SHALL be 0.
REQ-028 bus_ack or bus_err in IDLE or RESP SHALL be ignored.

Reset
REQ-029 Assertion of reset SHALL immediately force IDLE with bus_req=0, mem_data_valid=0, mem_data_access_fault=0, mem_data_misalign=0, mem_data_in=0, bus_addr=0, and timeout counter=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction; a late bus_ack SHALL then be ignored per REQ-028.

Configuration
REQ-031 With DATA_MEM_PORT_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ/DRAIN and increment every cycle there. When it reaches TIMEOUT_CYCLES without ack/err: REQ SHALL go to RESP with fault=1; DRAIN SHALL go to IDLE. In both cases bus_req SHALL drop.
REQ-032 Without DATA_MEM_PORT_TIMEOUT_EN, no counter SHALL exist, and REQ/DRAIN SHALL wait indefinitely.

Structure
REQ-033 Package data_mem_port_pkg SHALL hold the FSM state enum, the size encodings (SIZE_BYTE/HALF/WORD), and TIMEOUT_CYCLES_DEFAULT.
REQ-034 A combinational sub-module data_mem_align SHALL perform the misalign check and the lane shift/mask; data_mem_port SHALL instantiate it once.

Verification
REQ-035 Word load at 0x1000, rdata 0xDEADBEEF, ack after 3 cycles -> bus_addr=0x400; one valid pulse with data 0xDEADBEEF, fault=0.
REQ-036 Byte load at 0x1003 with rdata 0x80112233 -> data 0x00000080; half load at 0x1002 -> data 0x00008011.
REQ-037 Half load at 0x1001 -> no bus_req; valid at cycle 1 with fault=1, misalign=1; size 11 at 0x1000 -> valid at cycle 1 with fault=1, misalign=0.
REQ-038 Flush while bus_req is high, ack 2 cycles later -> bus_req held until ack; no mem_data_valid; next load completes normally.
REQ-039 bus_err and bus_ack in the same cycle -> valid with fault=1 and data 0.
REQ-040 With TIMEOUT_CYCLES=4 and no ack -> fault pulse 4 cycles after bus_req rises; reset asserted mid-REQ -> outputs 0 immediately.
